rom_read_arbiter: RTL
=====================

// Module: rom_read_arbiter
// PURPOSE
// - Shares one synchronous boot-ROM macro port (enable/read/12-bit word address, 1-cycle data) among NUM_REQ read clients.
// - Round-robin, burst-granular: a granted burst runs to completion before re-arbitration.
// - Sits between the ROM macro and its clients (AXI ROM slave path, boot DMA, debug reader).
// PARAMETERS
// - NUM_REQ    2             number of clients (2..4)
// - BASE_ADDR  32'h0000_0000 byte address mapped to ROM word 0
// PORTS
// - clk          in   1          single clock, rising edge
// - rst          in   1          synchronous reset, active-high
// - REQ_VALID    in   NUM_REQ    per-client burst request valid
// - REQ_READY    out  NUM_REQ    per-client request accept (one-hot or zero)
// - REQ_ADDR     in   NUM_REQ*32 per-client start byte address (word aligned)
// - REQ_LEN      in   NUM_REQ*4  per-client beats-1 (0..15 => 1..16 beats)
// - RSP_VALID    out  NUM_REQ    per-client data beat valid (one-hot or zero)
// - RSP_DATA     out  32         beat data, shared by all clients (= ROM_out)
// - RSP_LAST     out  1          final beat of current burst
// - RSP_READY    in   NUM_REQ    per-client beat accept
// - ROM_out      in   32         ROM data, valid 1 cycle after enabled address
// - ROM_enable   out  1          ROM chip enable
// - ROM_read     out  1          ROM read strobe
// - ROM_address  out  12         ROM word address = (byte_addr - BASE_ADDR)[13:2]
// BEHAVIOUR
// - FSM states IDLE, RESP; reset: IDLE, rr_ptr=0, beat_cnt=0; all outputs 0 (RSP_DATA follows ROM_out).
// - IDLE: grant g = first index >= rr_ptr (circular) with REQ_VALID; REQ_READY[g]=1 combinationally, others 0.
//   On grant: latch id=g, addr, len; ROM_enable=1, ROM_address from REQ_ADDR[g]; beat_cnt=0; -> RESP.
// - RESP: ROM_enable=1, ROM_read=1, ROM_address=current addr; RSP_VALID[id]=1; RSP_LAST=(beat_cnt==len).
//   RSP_READY[id]=0: hold addr (ROM re-reads same word, data stable).
//   RSP_READY[id]=1, not last: addr+=4, beat_cnt+=1, ROM_address driven from new addr same cycle -> back-to-back beats.
//   RSP_READY[id]=1, last: rr_ptr=(id+1) mod NUM_REQ, -> IDLE. REQ_READY all 0 during RESP.
// - Latency: accept cycle N -> first RSP_VALID at N+1; min one IDLE bubble between bursts.
// - RSP_READY of non-owner clients ignored. REQ_LEN/REQ_ADDR sampled only at accept.
// - Address arithmetic 32-bit; ROM_address truncates to 12 bits: word 4095 +1 wraps to word 0.
// - Simultaneous REQ_VALID: rr_ptr decides; single requester granted regardless of rr_ptr.
// - rst mid-burst: next cycle IDLE, burst dropped, no further RSP_VALID/RSP_LAST for it, rr_ptr=0.
// CONFIGURATION
// - ROM_ARB_RANGE_CHK_EN defined: extra port RSP_ERR out 1; beat with byte addr < BASE_ADDR or >= BASE_ADDR+16KiB
//   sets RSP_ERR=1 with RSP_VALID, RSP_DATA=32'h0, ROM_enable=0 for that beat; burst continues to RSP_LAST.
// - Undefined: no RSP_ERR port, no check; address truncates/wraps as above.
// TESTING
// - Client0 ADDR=BASE+0x10, LEN=0, RSP_READY=1 -> ROM_address=4 in accept cycle, 1 beat next cycle, RSP_LAST=1, IDLE after.
// - Client1 ADDR=BASE+0x0, LEN=3, RSP_READY low 2 cycles on beat 1 -> addresses 0,1,1,1,2,3; RSP_DATA stable while stalled; LAST on beat 3.
// - Both REQ_VALID held, LEN=1 each, from reset -> grant order 0,1,0,1; REQ_READY never two-hot.
// - ADDR=BASE+0x3FF8, LEN=3 -> ROM_address 4094,4095,0,1 (macro off); macro on: beats 2,3 RSP_ERR=1, data 0.
// - rst asserted on beat 2 of LEN=7 burst -> next cycle RSP_VALID=0, ROM_enable=0, state IDLE, rr_ptr=0.
// - Non-owner RSP_READY toggling during burst -> no effect on beat count or addresses.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// Round-robin, burst-granular arbiter sharing one synchronous boot-ROM port among NUM_REQ clients.
// Optional `ROM_ARB_RANGE_CHK_EN adds o_rsp_err and blocks ROM access for beats outside the 16 KiB window.
module rom_read_arbiter #(
  parameter int          NUM_REQ   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [NUM_REQ*32-1:0]  i_req_addr,
  input  logic [NUM_REQ*4-1:0]   i_req_len,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [31:0]            o_rsp_data,
  output logic                   o_rsp_last,
  input  logic [NUM_REQ-1:0]     i_rsp_ready,
  input  logic [31:0]            i_rom_out,
  output logic                   o_rom_enable,
  output logic                   o_rom_read,
  output logic [11:0]            o_rom_address
`ifdef ROM_ARB_RANGE_CHK_EN
  ,
  output logic                   o_rsp_err
`endif
);

  // state  | meaning
  // S_IDLE | arbitrate; on grant present first word address to the ROM
  // S_RESP | stream beats to owner r_id; address leads data by one cycle
  localparam int IDW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [31:0]      r_addr;
  logic [3:0]       r_len;
  logic [3:0]       r_beat_cnt;

  logic             w_gnt_found;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_accept;
  logic             w_own_ready;
  logic             w_last;
  logic             w_advance;
  logic             w_done;
  logic [31:0]      w_sel_addr;
  logic [3:0]       w_sel_len;
  logic [31:0]      w_pres_addr;
  logic [11:0]      w_rom_word;
  logic             w_rom_cs;

  // Descending scan so the lowest circular offset from r_rr_ptr wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_accept    = (r_state == S_IDLE) && w_gnt_found && !rst;
  assign w_sel_addr  = i_req_addr[int'(w_gnt_id)*32 +: 32];
  assign w_sel_len   = i_req_len[int'(w_gnt_id)*4 +: 4];
  assign w_own_ready = i_rsp_ready[r_id];
  assign w_last      = (r_beat_cnt == r_len);
  assign w_advance   = (r_state == S_RESP) && w_own_ready && !w_last;
  assign w_done      = (r_state == S_RESP) && w_own_ready && w_last;

  // Address presented to the ROM this cycle: the word whose data appears next cycle.
  assign w_pres_addr = (r_state == S_IDLE) ? w_sel_addr :
                       (w_advance ? r_addr + 32'd4 : r_addr);
  assign w_rom_word  = 12'((w_pres_addr - BASE_ADDR) >> 2);

`ifdef ROM_ARB_RANGE_CHK_EN
  logic r_err;
  logic w_oor;
  assign w_oor    = ({1'b0, w_pres_addr} <  {1'b0, BASE_ADDR}) ||
                    ({1'b0, w_pres_addr} >= ({1'b0, BASE_ADDR} + 33'd16384));
  assign w_rom_cs = !w_oor;

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_accept || (r_state == S_RESP))
      r_err <= w_oor;
  end
`else
  assign w_rom_cs = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RESP;
      S_RESP:  if (w_done)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_id       <= w_gnt_id;
        r_addr     <= w_sel_addr;
        r_len      <= w_sel_len;
        r_beat_cnt <= '0;
      end
      if (w_advance) begin
        r_addr     <= r_addr + 32'd4;
        r_beat_cnt <= r_beat_cnt + 4'd1;
      end
      if (w_done)
        r_rr_ptr <= IDW'((int'(r_id) + 1) % NUM_REQ);
    end
  end

  always_comb begin
    o_req_ready   = '0;
    o_rsp_valid   = '0;
    o_rsp_last    = 1'b0;
    o_rom_enable  = 1'b0;
    o_rom_read    = 1'b0;
    o_rom_address = '0;
    o_rsp_data    = i_rom_out;
`ifdef ROM_ARB_RANGE_CHK_EN
    o_rsp_err     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          o_req_ready[w_gnt_id] = 1'b1;
          o_rom_enable          = w_rom_cs;
          o_rom_address         = w_rom_word;
        end
      end
      S_RESP: begin
        o_rom_enable      = w_rom_cs;
        o_rom_read        = 1'b1;
        o_rom_address     = w_rom_word;
        o_rsp_valid[r_id] = 1'b1;
        o_rsp_last        = w_last;
`ifdef ROM_ARB_RANGE_CHK_EN
        o_rsp_err         = r_err;
        if (r_err) o_rsp_data = 32'h0;
`endif
      end
      default: ;
    endcase
  end

endmodule
